// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Parametrised VGA timing generator with pixel-tick divider,
//            sync polarity control, enable/freeze and line/frame strobes.
//            Define VGA_TIMING_FRAME_CNT_EN to add a 16-bit frame counter.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int CLK_DIV   = 1,
  parameter int CNT_W     = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             video_on,
  output logic             hsync,
  output logic             vsync,
  output logic             p_tick,
  output logic             line_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic             frame_start,
  output logic [15:0]      frame_cnt
`else
  output logic             frame_start
`endif
);

  localparam int c_h_total    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_v_total    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int c_hs_start   = H_ACTIVE + H_FP;
  localparam int c_hs_end     = H_ACTIVE + H_FP + H_SYNC;
  localparam int c_vs_start   = V_ACTIVE + V_FP;
  localparam int c_vs_end     = V_ACTIVE + V_FP + V_SYNC;
  localparam int c_div_w      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic c_hs_pol   = (HSYNC_POL != 0);
  localparam logic c_vs_pol   = (VSYNC_POL != 0);

  logic             w_div_last;
  logic             w_h_last;
  logic             w_v_last;
  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;

  // With no division every enabled clock is a pixel tick.
  generate
    if (CLK_DIV <= 1) begin : g_div_bypass
      assign w_div_last = 1'b1;
    end else begin : g_div_count
      logic [c_div_w-1:0] r_div_cnt;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_div_cnt <= '0;
        end else if (en) begin
          if (r_div_cnt == c_div_w'(CLK_DIV - 1)) begin
            r_div_cnt <= '0;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
      end

      assign w_div_last = (r_div_cnt == c_div_w'(CLK_DIV - 1));
    end
  endgenerate

  assign p_tick   = en & w_div_last;
  assign w_h_last = (r_h_cnt == CNT_W'(c_h_total - 1));
  assign w_v_last = (r_v_cnt == CNT_W'(c_v_total - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (p_tick) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (p_tick && w_h_last && w_v_last) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

  // Every output is a pure decode of the counters so all describe one pixel.
  assign pixel_x     = r_h_cnt;
  assign pixel_y     = r_v_cnt;
  assign video_on    = (r_h_cnt < CNT_W'(H_ACTIVE)) && (r_v_cnt < CNT_W'(V_ACTIVE));
  assign hsync       = ((r_h_cnt >= CNT_W'(c_hs_start)) && (r_h_cnt < CNT_W'(c_hs_end)))
                       ? c_hs_pol : ~c_hs_pol;
  assign vsync       = ((r_v_cnt >= CNT_W'(c_vs_start)) && (r_v_cnt < CNT_W'(c_vs_end)))
                       ? c_vs_pol : ~c_vs_pol;
  assign line_start  = p_tick && (r_h_cnt == '0);
  assign frame_start = p_tick && (r_h_cnt == '0) && (r_v_cnt == '0);

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Bench for vga_timing_gen: two small-geometry instances (undivided
//            active-low, divide-by-3 active-high) against a position model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 4, HS = 6, HB = 5;
  localparam int VA = 10, VF = 2, VS = 3, VB = 4;
  localparam int CW = 6;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int VW = 2 * CW + 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  always #5 clk = ~clk;

  logic [CW-1:0] ax, ay, bx, by;
  logic a_von, a_hs, a_vs, a_pt, a_ls, a_fs;
  logic b_von, b_hs, b_vs, b_pt, b_ls, b_fs;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] a_fc, b_fc;
`endif

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(0), .VSYNC_POL(0), .CLK_DIV(1), .CNT_W(CW)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en),
    .pixel_x(ax), .pixel_y(ay), .video_on(a_von), .hsync(a_hs), .vsync(a_vs),
    .p_tick(a_pt), .line_start(a_ls),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_start(a_fs), .frame_cnt(a_fc)
`else
    .frame_start(a_fs)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1), .VSYNC_POL(1), .CLK_DIV(3), .CNT_W(CW)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en),
    .pixel_x(bx), .pixel_y(by), .video_on(b_von), .hsync(b_hs), .vsync(b_vs),
    .p_tick(b_pt), .line_start(b_ls),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_start(b_fs), .frame_cnt(b_fc)
`else
    .frame_start(b_fs)
`endif
  );

  logic [VW-1:0] act_vec [2];
  assign act_vec[0] = {ax, ay, a_von, a_hs, a_vs, a_pt, a_ls, a_fs};
  assign act_vec[1] = {bx, by, b_von, b_hs, b_vs, b_pt, b_ls, b_fs};

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each instance is a clock phase plus a linear pixel position in the frame.
  int div_of [2] = '{1, 3};
  bit pol_of [2] = '{1'b0, 1'b1};
  int m_phase [2];
  int m_pos [2];
  int m_frames [2];
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_phase[i]  <= 0;
        m_pos[i]    <= 0;
        m_frames[i] <= 0;
      end
      m_valid <= 1'b1;
    end else if (en && m_valid) begin
      for (int i = 0; i < 2; i++) begin
        if (m_phase[i] == div_of[i] - 1) begin
          m_phase[i] <= 0;
          m_pos[i]   <= (m_pos[i] + 1) % FRAME;
          if (m_pos[i] == FRAME - 1) m_frames[i] <= (m_frames[i] + 1) % 65536;
        end else begin
          m_phase[i] <= m_phase[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    int x, y;
    logic von, hs, vs, tk, ls, fs;
    logic [VW-1:0] e;
    if (m_valid) begin
      for (int i = 0; i < 2; i++) begin
        x   = m_pos[i] % HT;
        y   = m_pos[i] / HT;
        tk  = en && (m_phase[i] == div_of[i] - 1);
        von = (x < HA) && (y < VA);
        hs  = (x >= HA + HF && x < HA + HF + HS) ? pol_of[i] : !pol_of[i];
        vs  = (y >= VA + VF && y < VA + VF + VS) ? pol_of[i] : !pol_of[i];
        ls  = tk && (x == 0);
        fs  = tk && (m_pos[i] == 0);
        e   = {CW'(x), CW'(y), von, hs, vs, tk, ls, fs};
        check(i == 0 ? "model_a_outputs" : "model_b_outputs", 32'(act_vec[i]), 32'(e));
      end
`ifdef VGA_TIMING_FRAME_CNT_EN
      check("model_a_frame_cnt", 32'(a_fc), 32'(m_frames[0]));
      check("model_b_frame_cnt", 32'(b_fc), 32'(m_frames[1]));
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_a_xy(input int x, input int y);
    int n = 0;
    while (!(ax == CW'(x) && ay == CW'(y)) && n < 5000) begin
      step(1);
      n++;
    end
    check("wait_a_xy_in_time", 32'(n < 5000), 32'd1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    en    = 1'b1;
    step(3);
    check("reset_a_x", 32'(ax), 32'd0);
    check("reset_a_von", 32'(a_von), 32'd1);
    check("reset_a_hs_idle", 32'(a_hs), 32'd1);
    check("reset_b_hs_idle", 32'(b_hs), 32'd0);
    check("reset_b_vs_idle", 32'(b_vs), 32'd0);

    // Hand-computed timing pins for the small geometry.
    rst_n = 1'b1;
    n = 0;
    while (a_hs !== 1'b0 && n < 1000) begin step(1); n++; end
    check("a_hsync_assert_clks", 32'(n), 32'(HA + HF));
    n = 0;
    while (a_hs === 1'b0 && n < 1000) begin step(1); n++; end
    check("a_hsync_width_clks", 32'(n), 32'(HS));
    n = 0;
    while (a_fs !== 1'b1 && n < 5000) begin step(1); n++; end
    step(1);
    n = 1;
    while (a_fs !== 1'b1 && n < 5000) begin step(1); n++; end
    check("a_frame_period_clks", 32'(n), 32'(FRAME));
    n = 0;
    while (a_vs !== 1'b0 && n < 5000) begin step(1); n++; end
    n = 0;
    while (a_vs === 1'b0 && n < 5000) begin step(1); n++; end
    check("a_vsync_width_clks", 32'(n), 32'(VS * HT));
    n = 0;
    while (b_ls !== 1'b1 && n < 5000) begin step(1); n++; end
    step(1);
    n = 1;
    while (b_ls !== 1'b1 && n < 5000) begin step(1); n++; end
    check("b_line_period_clks", 32'(n), 32'(3 * HT));

    // Freeze mid-frame and resume.
    wait_a_xy(12, 5);
    en = 1'b0;
    step(25);
    check("hold_a_x", 32'(ax), 32'd12);
    check("hold_a_y", 32'(ay), 32'd5);
    check("hold_a_tick", 32'(a_pt), 32'd0);
    en = 1'b1;
    step(1);
    check("resume_a_x", 32'(ax), 32'd13);

    // Reset mid-frame.
    wait_a_xy(3, 7);
    rst_n = 1'b0;
    step(1);
    check("midreset_a_xy", 32'({ax, ay}), 32'd0);
    check("midreset_b_xy", 32'({bx, by}), 32'd0);
    rst_n = 1'b1;
`ifdef VGA_TIMING_FRAME_CNT_EN
    step(3 * 3 * FRAME);
    check("b_frame_cnt_3", 32'(b_fc), 32'd3);
    check("a_frame_cnt_9", 32'(a_fc), 32'd9);
    rst_n = 1'b0;
    step(1);
    check("frame_cnt_reset", 32'(b_fc), 32'd0);
    rst_n = 1'b1;
`endif

    // Random enable gaps and occasional resets, checked by the model.
    for (int k = 0; k < 15000; k++) begin
      en    = ($urandom_range(0, 9) != 0);
      rst_n = ($urandom_range(0, 499) != 0);
      step(1);
    end
    en = 1'b1;
    rst_n = 1'b1;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
